// File: rtl/stmt_loop_sequencer.sv
// rtl/stmt_loop_sequencer.sv - while/do-while/bounded loop sequencer with accumulator
// Accepts one loop request in IDLE, iterates in RUN, and holds its result in DONE until consumed.
module stmt_loop_sequencer #(
   parameter  int DATA_W   = 8,
   parameter  int MAX_ITER = 16,
   localparam int CNT_W    = $clog2(MAX_ITER + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] init_data,
   input  logic [DATA_W-1:0] step,
   input  logic [DATA_W-1:0] limit,
   input  logic              abort,
   output logic              done_valid,
   input  logic              done_ready,
   output logic [DATA_W-1:0] result,
   output logic [CNT_W-1:0]  iter_count,
   output logic              timeout,
   output logic              aborted
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ITER_MAX = CNT_W'(MAX_ITER);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_mode;
   logic [DATA_W-1:0] r_step;
   logic [DATA_W-1:0] r_limit;
   logic [DATA_W-1:0] r_acc;
   logic [CNT_W-1:0]  r_iter;
   logic              r_first;
   logic              r_timeout;
   logic              r_aborted;

   logic w_accept;
   logic w_body;
   logic w_set_abort;
   logic w_set_timeout;
   logic w_eval;
   logic w_cond;

   // Do-while skips the test on its first pass; forever-bounded never tests; mode 3 acts as while.
   assign w_eval = (r_mode == 2'd2) ? 1'b0 :
                   (r_mode == 2'd1) ? ~r_first : 1'b1;
   assign w_cond = (r_acc < r_limit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_accept      = 1'b0;
      w_body        = 1'b0;
      w_set_abort   = 1'b0;
      w_set_timeout = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               w_set_abort = 1'b1;
               w_state_nxt = DONE;
            end else if (w_eval && !w_cond) begin
               w_state_nxt = DONE;
            end else if (r_iter == ITER_MAX) begin
               w_set_timeout = 1'b1;
               w_state_nxt   = DONE;
            end else begin
               w_body = 1'b1;
            end
         end
         DONE: begin
            if (done_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode    <= 2'd0;
         r_step    <= '0;
         r_limit   <= '0;
         r_acc     <= '0;
         r_iter    <= '0;
         r_first   <= 1'b0;
         r_timeout <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         if (w_accept) begin
            r_mode    <= mode;
            r_step    <= step;
            r_limit   <= limit;
            r_acc     <= init_data;
            r_iter    <= '0;
            r_first   <= 1'b1;
            r_timeout <= 1'b0;
            r_aborted <= 1'b0;
         end
         if (w_body) begin
            r_acc   <= r_acc + r_step;
            r_iter  <= r_iter + 1'b1;
            r_first <= 1'b0;
         end
         if (w_set_abort) begin
            r_aborted <= 1'b1;
         end
         if (w_set_timeout) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign start_ready = (r_state == IDLE);
   assign done_valid  = (r_state == DONE);
   assign result      = r_acc;
   assign iter_count  = r_iter;
   assign timeout     = r_timeout;
   assign aborted     = r_aborted;

endmodule

// File: tb/tb_stmt_loop_sequencer.sv
// tb/tb_stmt_loop_sequencer.sv - directed bench for stmt_loop_sequencer
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_stmt_loop_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start_valid;
   logic       start_ready;
   logic [1:0] mode;
   logic [7:0] init_data;
   logic [7:0] step;
   logic [7:0] limit;
   logic       abort;
   logic       done_valid;
   logic       done_ready;
   logic [7:0] result;
   logic [4:0] iter_count;
   logic       timeout;
   logic       aborted;

   int n_tests;
   int n_fail;

   stmt_loop_sequencer #(.DATA_W(8), .MAX_ITER(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .mode        (mode),
      .init_data   (init_data),
      .step        (step),
      .limit       (limit),
      .abort       (abort),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .result      (result),
      .iter_count  (iter_count),
      .timeout     (timeout),
      .aborted     (aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one request and waits for done_valid; leaves the sequencer in DONE.
   task automatic do_loop(input logic [1:0] m, input logic [7:0] ini, input logic [7:0] stp,
                          input logic [7:0] lim, output int lat);
      mode        = m;
      init_data   = ini;
      step        = stp;
      limit       = lim;
      start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      lat = 1;
      while (!done_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_done();
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_tests++;
      if (start_ready !== 1'b1 || done_valid !== 1'b0 || result !== 8'd0 ||
          iter_count !== 5'd0 || timeout !== 1'b0 || aborted !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: rdy=%b dv=%b res=%0d it=%0d to=%b ab=%b expected 1 0 0 0 0 0",
                  start_ready, done_valid, result, iter_count, timeout, aborted);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_while_false();
      int lat;
      do_loop(2'd0, 8'd10, 8'd1, 8'd5, lat);
      n_tests++;
      if (lat !== 2 || result !== 8'd10 || iter_count !== 5'd0 || timeout !== 1'b0 || aborted !== 1'b0) begin
         n_fail++;
         $display("FAIL while_false: lat=%0d res=%0d it=%0d to=%b ab=%b expected 2 10 0 0 0",
                  lat, result, iter_count, timeout, aborted);
      end
      release_done();
      n_tests++;
      if (done_valid !== 1'b0 || start_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL while_release: dv=%b rdy=%b expected 0 1", done_valid, start_ready);
      end
   endtask

   task automatic test_do_while();
      int lat;
      do_loop(2'd1, 8'd10, 8'd1, 8'd5, lat);
      n_tests++;
      if (lat !== 3 || result !== 8'd11 || iter_count !== 5'd1 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL do_while: lat=%0d res=%0d it=%0d to=%b expected 3 11 1 0",
                  lat, result, iter_count, timeout);
      end
      release_done();
   endtask

   task automatic test_accumulate();
      int lat;
      do_loop(2'd0, 8'd0, 8'd3, 8'd10, lat);
      n_tests++;
      if (lat !== 6 || result !== 8'd12 || iter_count !== 5'd4 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL while_accum: lat=%0d res=%0d it=%0d to=%b expected 6 12 4 0",
                  lat, result, iter_count, timeout);
      end
      release_done();
      do_loop(2'd1, 8'd250, 8'd10, 8'd5, lat);
      n_tests++;
      if (lat !== 4 || result !== 8'd14 || iter_count !== 5'd2 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL do_while_wrap: lat=%0d res=%0d it=%0d to=%b expected 4 14 2 0",
                  lat, result, iter_count, timeout);
      end
      release_done();
   endtask

   task automatic test_timeout();
      int lat;
      do_loop(2'd0, 8'd0, 8'd0, 8'd1, lat);
      n_tests++;
      if (lat !== 18 || result !== 8'd0 || iter_count !== 5'd16 || timeout !== 1'b1 || aborted !== 1'b0) begin
         n_fail++;
         $display("FAIL step0_timeout: lat=%0d res=%0d it=%0d to=%b ab=%b expected 18 0 16 1 0",
                  lat, result, iter_count, timeout, aborted);
      end
      release_done();
      do_loop(2'd2, 8'd0, 8'd1, 8'd0, lat);
      n_tests++;
      if (lat !== 18 || result !== 8'd16 || iter_count !== 5'd16 || timeout !== 1'b1 || aborted !== 1'b0) begin
         n_fail++;
         $display("FAIL forever_timeout: lat=%0d res=%0d it=%0d to=%b ab=%b expected 18 16 16 1 0",
                  lat, result, iter_count, timeout, aborted);
      end
      release_done();
   endtask

   task automatic test_abort_hold();
      int held_bad;
      mode        = 2'd2;
      init_data   = 8'd0;
      step        = 8'd1;
      limit       = 8'd0;
      start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_tests++;
      if (done_valid !== 1'b1 || aborted !== 1'b1 || timeout !== 1'b0 ||
          iter_count !== 5'd4 || result !== 8'd4) begin
         n_fail++;
         $display("FAIL abort: dv=%b ab=%b to=%b it=%0d res=%0d expected 1 1 0 4 4",
                  done_valid, aborted, timeout, iter_count, result);
      end
      start_valid = 1'b1;
      mode        = 2'd0;
      init_data   = 8'd77;
      abort       = 1'b1;
      held_bad    = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done_valid !== 1'b1 || start_ready !== 1'b0 || aborted !== 1'b1 ||
             timeout !== 1'b0 || iter_count !== 5'd4 || result !== 8'd4) begin
            held_bad++;
         end
      end
      start_valid = 1'b0;
      abort       = 1'b0;
      n_tests++;
      if (held_bad !== 0) begin
         n_fail++;
         $display("FAIL abort_hold: %0d unstable cycles, expected 0", held_bad);
      end
      release_done();
   endtask

   task automatic test_reset_mid_run();
      int lat;
      int dv_seen;
      mode        = 2'd2;
      init_data   = 8'd0;
      step        = 8'd1;
      limit       = 8'd0;
      start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (iter_count !== 5'd3 || done_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_reset_iter: it=%0d dv=%b expected 3 0", iter_count, done_valid);
      end
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if (start_ready !== 1'b1 || done_valid !== 1'b0 || result !== 8'd0 ||
          iter_count !== 5'd0 || timeout !== 1'b0 || aborted !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: rdy=%b dv=%b res=%0d it=%0d to=%b ab=%b expected 1 0 0 0 0 0",
                  start_ready, done_valid, result, iter_count, timeout, aborted);
      end
      dv_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (done_valid !== 1'b0) dv_seen++;
      end
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (done_valid !== 1'b0) dv_seen++;
      end
      n_tests++;
      if (dv_seen !== 0) begin
         n_fail++;
         $display("FAIL reset_no_done: done_valid seen %0d cycles, expected 0", dv_seen);
      end
      do_loop(2'd0, 8'd0, 8'd3, 8'd10, lat);
      n_tests++;
      if (lat !== 6 || result !== 8'd12 || iter_count !== 5'd4) begin
         n_fail++;
         $display("FAIL after_reset: lat=%0d res=%0d it=%0d expected 6 12 4", lat, result, iter_count);
      end
      release_done();
   endtask

   task automatic test_back_to_back();
      int lat;
      do_loop(2'd3, 8'd0, 8'd3, 8'd10, lat);
      n_tests++;
      if (lat !== 6 || result !== 8'd12 || iter_count !== 5'd4 || timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL mode3: lat=%0d res=%0d it=%0d to=%b expected 6 12 4 0",
                  lat, result, iter_count, timeout);
      end
      done_ready  = 1'b1;
      start_valid = 1'b1;
      mode        = 2'd1;
      init_data   = 8'd10;
      step        = 8'd1;
      limit       = 8'd5;
      @(negedge clk);
      done_ready = 1'b0;
      n_tests++;
      if (start_ready !== 1'b1 || done_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL no_accept_in_done: rdy=%b dv=%b expected 1 0", start_ready, done_valid);
      end
      do_loop(2'd1, 8'd10, 8'd1, 8'd5, lat);
      n_tests++;
      if (lat !== 3 || result !== 8'd11 || iter_count !== 5'd1) begin
         n_fail++;
         $display("FAIL back_to_back: lat=%0d res=%0d it=%0d expected 3 11 1", lat, result, iter_count);
      end
      release_done();
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      start_valid = 1'b0;
      mode        = 2'd0;
      init_data   = 8'd0;
      step        = 8'd0;
      limit       = 8'd0;
      abort       = 1'b0;
      done_ready  = 1'b0;
      test_reset();
      test_while_false();
      test_do_while();
      test_accumulate();
      test_timeout();
      test_abort_hold();
      test_reset_mid_run();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stmt_loop_sequencer.md
STMT_LOOP_SEQUENCER -- requirements
Module: stmt_loop_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, accumulator/limit/step width in bits.
REQ-002 Parameter MAX_ITER, default 16, iteration bound; CNT_W = clog2(MAX_ITER+1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start_valid  input  1  loop request valid.
REQ-006 start_ready  output  1  sequencer can accept a request.
REQ-007 mode  input  2  loop form: 0 = while, 1 = do-while, 2 = forever-bounded, 3 = reserved.
REQ-008 init_data  input  DATA_W  initial accumulator value.
REQ-009 step  input  DATA_W  per-iteration increment.
REQ-010 limit  input  DATA_W  loop condition bound; condition = (acc < limit), unsigned.
REQ-011 abort  input  1  terminate running loop.
REQ-012 done_valid  output  1  result valid.
REQ-013 done_ready  input  1  result consumed.
REQ-014 result  output  DATA_W  final accumulator.
REQ-015 iter_count  output  CNT_W  number of body executions.
REQ-016 timeout  output  1  loop ended by reaching MAX_ITER.
REQ-017 aborted  output  1  loop ended by abort.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DONE; only IDLE drives start_ready=1, only DONE drives done_valid=1.
REQ-019 IDLE: on start_valid && start_ready, latch mode/init_data/step/limit, set acc=init_data, iter=0, first=1, clear flags, go RUN.
REQ-020 Mode 3 SHALL behave exactly as mode 0.
REQ-021 RUN, one decision per cycle, priority: abort -> set aborted, go DONE; else condition-exit; else bound-exit; else body.
REQ-022 Condition-exit: modes 0/3 evaluate condition every RUN cycle; mode 1 skips evaluation while first=1; mode 2 never evaluates; false condition -> go DONE, no body.
REQ-023 Bound-exit: iter == MAX_ITER -> set timeout, go DONE, no body.
REQ-024 Body: acc <= acc + step modulo 2^DATA_W (carry discarded), iter <= iter + 1, first <= 0, stay RUN.
REQ-025 Latency: with N body executions and no abort, done_valid SHALL rise N+2 cycles after the accept edge (accept edge -> RUN, N body edges, 1 exit edge).
REQ-026 DONE: result=acc, iter_count=iter, timeout, aborted held stable while done_valid && !done_ready.
REQ-027 DONE with done_ready=1: return to IDLE on that edge; done_valid low next cycle; no new request accepted in the same cycle.
REQ-028 start_valid and inputs SHALL be ignored outside IDLE; abort ignored outside RUN.
REQ-029 step=0 with condition true SHALL run to MAX_ITER and end with timeout=1.
REQ-030 timeout and aborted SHALL never both be 1.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, start_ready=1, done_valid=0, result=0, iter_count=0, timeout=0, aborted=0, acc=0, iter=0.
REQ-032 Reset asserted during RUN or DONE SHALL discard the loop with no done_valid pulse.
REQ-033 First accept possible on the first rising edge after rst_n deasserts.

Verification (DATA_W=8, MAX_ITER=16)
REQ-034 mode 0, init=10, limit=5, step=1 -> done_valid 2 cycles after accept, result=10, iter_count=0, timeout=0.
REQ-035 mode 1, same inputs -> result=11, iter_count=1, done_valid 3 cycles after accept.
REQ-036 mode 0, init=0, step=3, limit=10 -> result=12, iter_count=4; mode 1, init=250, step=10, limit=5 -> wraps to 4, then 14, result=14, iter_count=2.
REQ-037 mode 0, init=0, step=0, limit=1 -> timeout=1, iter_count=16, result=0; mode 2, step=1 -> timeout=1, result=16.
REQ-038 mode 2 with abort pulsed on 5th RUN cycle -> aborted=1, iter_count=4; hold done_ready=0 for 10 cycles -> outputs unchanged, start_valid ignored.
REQ-039 rst_n pulsed low mid-RUN (iter=3) -> all outputs zero, start_ready=1 asynchronously, no done_valid; next request completes normally.
